sram_bank_sequencer: RTL and testbench

//  Sequences the 2-port SRAM register bank against the Bennett square-clock phases.

---
 rtl/sram_bank_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sram_bank_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_sequencer.sv
// sram_bank_sequencer: sequences a 2-port SRAM bank against Bennett clock phases with round-robin read/write arbitration
module sram_bank_sequencer #(
  parameter int PHASES = 10,
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASES-1:0] clkp,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_ack,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data_a,
  output logic [DW-1:0]     rd_data_b,
  input  logic [DW-1:0]     sram_out_a,
  input  logic [DW-1:0]     sram_out_b,
  output logic [AW-1:0]     sram_addr_a,
  output logic [AW-1:0]     sram_addr_b,
  output logic [DW-1:0]     sram_din,
  output logic              sram_read_en,
  output logic              sram_write_en,
  output logic              sram_regwrtbar
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, EN, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [PHASES-1:0] clkp_q, rise, fall;
  logic rr_q, rr_d, op_q, op_d, go, pick_rd, unused_edges;
  logic [AW-1:0] la_q, la_d, lb_q, lb_d, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DW-1:0] ld_q, ld_d, din_q, din_d, rda_q, rda_d, rdb_q, rdb_d;
  logic wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, wr_done_q, wr_done_d, rd_valid_q, rd_valid_d;
  logic ren_q, ren_d, wen_q, wen_d, rwb_q, rwb_d;
  assign rise = clkp & ~clkp_q;
  assign fall = ~clkp & clkp_q;
  assign unused_edges = ^{rise, fall};
  assign pick_rd = rd_req && (!wr_req || rr_q);
  assign go = state_q == IDLE && rise[0] && (wr_req || rd_req);
  assign wr_ack = wr_ack_q;
  assign rd_ack = rd_ack_q;
  assign wr_done = wr_done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data_a = rda_q;
  assign rd_data_b = rdb_q;
  assign sram_addr_a = addr_a_q;
  assign sram_addr_b = addr_b_q;
  assign sram_din = din_q;
  assign sram_read_en = ren_q;
  assign sram_write_en = wen_q;
  assign sram_regwrtbar = rwb_q;
  always_ff @(posedge clk) begin
    clkp_q <= clkp;
    if (reset) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      op_q <= 1'b0;
      la_q <= '0;
      lb_q <= '0;
      ld_q <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      din_q <= '0;
      rda_q <= '0;
      rdb_q <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      rwb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      op_q <= op_d;
      la_q <= la_d;
      lb_q <= lb_d;
      ld_q <= ld_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      din_q <= din_d;
      rda_q <= rda_d;
      rdb_q <= rdb_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      wr_done_q <= wr_done_d;
      rd_valid_q <= rd_valid_d;
      ren_q <= ren_d;
      wen_q <= wen_d;
      rwb_q <= rwb_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? ADDR : IDLE;
      ADDR:    state_d = rise[2] ? DATA : ADDR;
      DATA:    state_d = rise[4] ? EN : DATA;
      EN:      state_d = rise[6] ? STROBE : EN;
      STROBE:  state_d = rise[9] ? HOLD : STROBE;
      HOLD:    state_d = fall[6] ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rr_d = rr_q;
    op_d = op_q;
    la_d = la_q;
    lb_d = lb_q;
    ld_d = ld_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    din_d = din_q;
    rda_d = rda_q;
    rdb_d = rdb_q;
    wr_ack_d = 1'b0;
    rd_ack_d = 1'b0;
    wr_done_d = 1'b0;
    rd_valid_d = 1'b0;
    ren_d = ren_q;
    wen_d = wen_q;
    rwb_d = rwb_q;
    if (go) begin
      op_d = pick_rd;
      wr_ack_d = !pick_rd;
      rd_ack_d = pick_rd;
      rr_d = (wr_req && rd_req) ? !rr_q : rr_q;
      la_d = pick_rd ? rd_addr_a : wr_addr;
      lb_d = pick_rd ? rd_addr_b : wr_addr;
      ld_d = wr_data;
    end
    if (state_q == ADDR && rise[2]) begin
      addr_a_d = la_q;
      addr_b_d = lb_q;
    end
    if (state_q == DATA && rise[4] && !op_q) din_d = ld_q;
    if (state_q == EN && rise[6]) begin
      ren_d = op_q;
      rwb_d = !op_q;
    end
    if (state_q == STROBE && rise[8]) begin
      ren_d = 1'b0;
      wen_d = !op_q;
    end
    if (state_q == STROBE && rise[9]) begin
      wen_d = 1'b0;
      rda_d = op_q ? sram_out_a : rda_q;
      rdb_d = op_q ? sram_out_b : rdb_q;
      rd_valid_d = op_q;
    end
    if (state_q == HOLD && fall[6]) begin
      rwb_d = 1'b0;
      wr_done_d = !op_q;
    end
  end
endmodule

// File: tb/tb_sram_bank_sequencer.sv
// tb_sram_bank_sequencer: directed checks of phase sequencing, arbitration and reset for sram_bank_sequencer
module tb_sram_bank_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [9:0] clkp;
  logic wr_req = 1'b1, rd_req = 1'b1;
  logic [4:0] wr_addr = 5'h02, rd_addr_a = 5'h00, rd_addr_b = 5'h00;
  logic [15:0] wr_data = 16'h1234;
  logic wr_ack, wr_done, rd_ack, rd_valid;
  logic [15:0] rd_data_a, rd_data_b, sram_out_a, sram_out_b, sram_din;
  logic [4:0] sram_addr_a, sram_addr_b;
  logic sram_read_en, sram_write_en, sram_regwrtbar;
  logic [15:0] mem [32] = '{default: 16'h0};
  int tests = 0, fails = 0, st = -1, sub = 0;
  int n_wack, n_rack, n_wdone, n_rval, n_we, n_we_bad, n_re, n_re_bad, n_rw, n_rw_bad;
  int wdone_st, wdone_sub, rval_st, rval_sub, n_both = 0, n_orphan = 0;
  sram_bank_sequencer dut (
    .clk(clk), .reset(reset), .clkp(clkp),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .sram_out_a(sram_out_a), .sram_out_b(sram_out_b),
    .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b), .sram_din(sram_din),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en), .sram_regwrtbar(sram_regwrtbar)
  );
  always #5 clk = ~clk;
  assign sram_out_a = mem[sram_addr_a];
  assign sram_out_b = mem[sram_addr_b];
  always @(posedge clk) if (sram_write_en && sram_regwrtbar) mem[sram_addr_a] <= sram_din;
  initial begin
    clkp = '0;
    forever for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k < 10) clkp[k] = 1'b1;
      else clkp[19-k] = 1'b0;
      st = k;
      sub = 0;
      @(posedge clk);
      #1;
      sub = 1;
    end
  end
  always @(negedge clk) begin
    if (wr_ack) n_wack++;
    if (rd_ack) n_rack++;
    if (wr_done) begin n_wdone++; wdone_st = st; wdone_sub = sub; end
    if (rd_valid) begin n_rval++; rval_st = st; rval_sub = sub; end
    if (sram_write_en) begin n_we++; if (!((st == 8 && sub == 1) || (st == 9 && sub == 0))) n_we_bad++; end
    if (sram_read_en) begin n_re++; if (!((st == 6 && sub == 1) || st == 7 || (st == 8 && sub == 0))) n_re_bad++; end
    if (sram_regwrtbar) begin n_rw++; if (!((st == 6 && sub == 1) || (st > 6 && st < 13) || (st == 13 && sub == 0))) n_rw_bad++; end
    if (sram_read_en && sram_write_en) n_both++;
    if (sram_write_en && !sram_regwrtbar) n_orphan++;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d failures so far", fails);
    $fatal(1);
  end
  task automatic clear_counts();
    {n_wack, n_rack, n_wdone, n_rval, n_we, n_we_bad, n_re, n_re_bad, n_rw, n_rw_bad} = '0;
    {wdone_st, wdone_sub, rval_st, rval_sub} = '0;
  endtask
  task automatic wait_at(input int k, input int s);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(st == k && sub == s) && n < 100);
    #1;
    if (!(st == k && sub == s)) begin tests++; fails++; $display("FAIL wait_at: step %0d.%0d reached instead of %0d.%0d", st, sub, k, s); end
  endtask
  task automatic test_reset();
    wait_at(0, 1);
    tests++; if ({wr_ack, rd_ack, wr_done, rd_valid, sram_read_en, sram_write_en, sram_regwrtbar} !== 7'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 0000000", {wr_ack, rd_ack, wr_done, rd_valid, sram_read_en, sram_write_en, sram_regwrtbar}); end
    tests++; if ({rd_data_a, rd_data_b, sram_addr_a, sram_addr_b, sram_din} !== 58'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {rd_data_a, rd_data_b, sram_addr_a, sram_addr_b, sram_din}); end
    tests++; if (n_wack + n_rack !== 0) begin fails++; $display("FAIL reset_noack: got %0d acks want 0", n_wack + n_rack); end
    wait_at(15, 1);
    reset = 1'b0;
    clear_counts();
    wait_at(0, 1);
    tests++; if ({wr_ack, rd_ack} !== 2'b10) begin fails++; $display("FAIL reset_first_grant: got %b want 10", {wr_ack, rd_ack}); end
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_at(19, 1);
    tests++; if (n_wdone !== 1 || n_rack !== 0) begin fails++; $display("FAIL reset_first_done: got wdone=%0d rack=%0d want 1,0", n_wdone, n_rack); end
  endtask
  task automatic test_write();
    wr_addr = 5'h1F;
    wr_data = 16'hAAAA;
    wr_req = 1'b1;
    clear_counts();
    wait_at(0, 0);
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL wr_ack_early: got %b want 0", wr_ack); end
    wait_at(0, 1);
    tests++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL wr_ack: got %b want 1", wr_ack); end
    wr_req = 1'b0;
    wait_at(2, 1);
    tests++; if ({sram_addr_a, sram_addr_b} !== {5'h1F, 5'h1F}) begin fails++; $display("FAIL wr_addr: got %h/%h want 1f/1f", sram_addr_a, sram_addr_b); end
    wait_at(4, 1);
    tests++; if (sram_din !== 16'hAAAA) begin fails++; $display("FAIL wr_din: got %h want aaaa", sram_din); end
    wait_at(6, 1);
    tests++; if (sram_regwrtbar !== 1'b1) begin fails++; $display("FAIL wr_regwrtbar_on: got %b want 1", sram_regwrtbar); end
    wait_at(13, 1);
    tests++; if ({sram_regwrtbar, wr_done} !== 2'b01) begin fails++; $display("FAIL wr_done_edge: got rwb,done=%b want 01", {sram_regwrtbar, wr_done}); end
    wait_at(19, 1);
    tests++; if (n_we !== 2 || n_we_bad !== 0) begin fails++; $display("FAIL wr_we_window: got %0d high, %0d outside want 2,0", n_we, n_we_bad); end
    tests++; if (n_rw !== 14 || n_rw_bad !== 0) begin fails++; $display("FAIL wr_rwb_window: got %0d high, %0d outside want 14,0", n_rw, n_rw_bad); end
    tests++; if (n_re !== 0) begin fails++; $display("FAIL wr_re_quiet: got %0d want 0", n_re); end
    tests++; if (n_wdone !== 1 || wdone_st !== 13 || wdone_sub !== 1) begin fails++; $display("FAIL wr_done_once: got %0d at %0d.%0d want 1 at 13.1", n_wdone, wdone_st, wdone_sub); end
  endtask
  task automatic test_read();
    rd_addr_a = 5'h1F;
    rd_addr_b = 5'h03;
    rd_req = 1'b1;
    clear_counts();
    wait_at(0, 1);
    tests++; if ({wr_ack, rd_ack} !== 2'b01) begin fails++; $display("FAIL rd_ack: got %b want 01", {wr_ack, rd_ack}); end
    rd_req = 1'b0;
    wait_at(2, 1);
    tests++; if ({sram_addr_a, sram_addr_b} !== {5'h1F, 5'h03}) begin fails++; $display("FAIL rd_addr: got %h/%h want 1f/03", sram_addr_a, sram_addr_b); end
    wait_at(4, 1);
    tests++; if (sram_din !== 16'hAAAA) begin fails++; $display("FAIL rd_din_hold: got %h want aaaa", sram_din); end
    wait_at(19, 1);
    tests++; if (n_re !== 4 || n_re_bad !== 0 || n_we !== 0) begin fails++; $display("FAIL rd_re_window: got re=%0d outside=%0d we=%0d want 4,0,0", n_re, n_re_bad, n_we); end
    tests++; if (n_rval !== 1 || rval_st !== 9 || rval_sub !== 1) begin fails++; $display("FAIL rd_valid_once: got %0d at %0d.%0d want 1 at 9.1", n_rval, rval_st, rval_sub); end
    tests++; if ({rd_data_a, rd_data_b} !== {16'hAAAA, 16'h0000}) begin fails++; $display("FAIL rd_data: got %h/%h want aaaa/0000", rd_data_a, rd_data_b); end
    tests++; if (n_wdone !== 0) begin fails++; $display("FAIL rd_no_wdone: got %0d want 0", n_wdone); end
  endtask
  task automatic test_reset_mid_write();
    wr_addr = 5'h0A;
    wr_data = 16'h5555;
    wr_req = 1'b1;
    clear_counts();
    wait_at(0, 1);
    tests++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL mid_ack: got %b want 1", wr_ack); end
    wait_at(6, 1);
    tests++; if (sram_regwrtbar !== 1'b1) begin fails++; $display("FAIL mid_rwb_on: got %b want 1", sram_regwrtbar); end
    wait_at(7, 0);
    reset = 1'b1;
    wait_at(7, 1);
    reset = 1'b0;
    tests++; if ({sram_regwrtbar, sram_write_en, sram_read_en, sram_addr_a, sram_din} !== 24'h0) begin fails++; $display("FAIL mid_reset_out: got %h want 0", {sram_regwrtbar, sram_write_en, sram_read_en, sram_addr_a, sram_din}); end
    wait_at(19, 1);
    tests++; if (n_we !== 0 || n_wdone !== 0) begin fails++; $display("FAIL mid_dropped: got we=%0d wdone=%0d want 0,0", n_we, n_wdone); end
    clear_counts();
    wait_at(0, 1);
    tests++; if ({wr_ack, rd_ack} !== 2'b10) begin fails++; $display("FAIL mid_regrant: got %b want 10", {wr_ack, rd_ack}); end
    wr_req = 1'b0;
    wait_at(19, 1);
    tests++; if (n_wdone !== 1) begin fails++; $display("FAIL mid_regrant_done: got %0d want 1", n_wdone); end
  endtask
  task automatic test_back_to_back();
    wr_addr = 5'h04;
    wr_data = 16'h1111;
    rd_addr_a = 5'h04;
    rd_addr_b = 5'h1F;
    wr_req = 1'b1;
    rd_req = 1'b1;
    clear_counts();
    for (int c = 0; c < 4; c++) begin
      wait_at(0, 1);
      tests++; if ({wr_ack, rd_ack} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL b2b_grant%0d: got %b want %b", c, {wr_ack, rd_ack}, (c % 2 == 0) ? 2'b10 : 2'b01); end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_at(19, 1);
    tests++; if (n_wack !== 2 || n_rack !== 2 || n_wdone !== 2 || n_rval !== 2) begin fails++; $display("FAIL b2b_counts: got wack=%0d rack=%0d wdone=%0d rval=%0d want 2,2,2,2", n_wack, n_rack, n_wdone, n_rval); end
  endtask
  task automatic test_late_request();
    clear_counts();
    wait_at(1, 1);
    rd_addr_a = 5'h1F;
    rd_addr_b = 5'h03;
    rd_req = 1'b1;
    wait_at(19, 1);
    tests++; if (n_rack !== 0) begin fails++; $display("FAIL late_no_ack: got %0d want 0", n_rack); end
    clear_counts();
    wait_at(0, 0);
    tests++; if (rd_ack !== 1'b0) begin fails++; $display("FAIL late_ack_early: got %b want 0", rd_ack); end
    wait_at(0, 1);
    tests++; if (rd_ack !== 1'b1) begin fails++; $display("FAIL late_ack: got %b want 1", rd_ack); end
    rd_req = 1'b0;
    wait_at(19, 1);
    tests++; if (n_rval !== 1 || {rd_data_a, rd_data_b} !== {16'hAAAA, 16'h0000}) begin fails++; $display("FAIL late_data: got %0d valid, %h/%h want 1, aaaa/0000", n_rval, rd_data_a, rd_data_b); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_reset_mid_write();
    test_back_to_back();
    test_late_request();
    tests++; if (n_both !== 0 || n_orphan !== 0) begin fails++; $display("FAIL invariants: got both=%0d orphan_we=%0d want 0,0", n_both, n_orphan); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
